mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
Control FSM for the multicycle MIPS datapath, replacing the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects, register and memory write enables, and the ALU control word. Memory latency and optional instruction support are set by parameters, so the same block serves both the zero-wait-state and the slow-memory builds.

Parameters:
MEM_LAT, 0, extra wait cycles per memory access (0..15); applies to FETCH, MEMRD and MEMWR.
ENABLE_BNE, 1, 1 = decode BNE (opcode 000101); 0 = treat it as illegal.
ENABLE_J, 1, 1 = decode J (opcode 000010); 0 = treat it as illegal.
ALU_CTRL_W, 3, width of alu_control.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
opcode  in  6  instr[31:26] from the instruction register
funct  in  6  instr[5:0] from the instruction register
zero  in  1  ALU zero flag
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  out  1  instruction register load
mem_write  out  1  data memory write
mem_to_reg  out  1  writeback select: 1 = memory data
reg_dst  out  1  destination select: 1 = rd
reg_write  out  1  register file write
alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = signimm, 11 = signimm<<2
pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en  out  1  PC load enable
alu_control  out  ALU_CTRL_W  ALU operation
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded
state_dbg  out  4  current state encoding

Behaviour:
- Reset and timing
  - Clocking: one clock (clk); reset is synchronous and active-high.
  - While reset is high, every output is 0. On the first edge with reset high, state goes to FETCH and wait_cnt to 0.
  - Reset asserted mid-instruction aborts it; no write enable is asserted on or after that edge.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP.
  - The outputs below are Moore outputs of the state; pc_en is the only output that also depends on zero.
  - Any output not listed for a state is 0.
- FETCH:
  - iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADD, pc_src=00.
  - ir_write=1 and pc_en=1 only on the final cycle, when wait_cnt==MEM_LAT.
  - Goes to DECODE.
- DECODE: alu_src_b=11, alu_control=ADD (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 001000 -> ADDIEX
  - 000100 -> BRANCH; 000101 -> BRANCH only if ENABLE_BNE
  - 000010 -> JUMP only if ENABLE_J
  - anything else -> FETCH with illegal_op=1 for one cycle; no write enable asserted.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1; advances to MEMWB when wait_cnt==MEM_LAT.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
- MEMWR: iord=1, with mem_write=1 on every cycle of the state; instr_done=1 on the final cycle.
- EXEC: alu_src_a=1, alu_src_b=00. alu_control decoded from funct:
  - 100000 ADD=010, 100010 SUB=110, 100100 AND=000, 100101 OR=001, 101010 SLT=111
  - any other funct gives ADD
- ALUWB: reg_write=1, reg_dst=1, instr_done=1.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD. ADDIWB: reg_write=1, reg_dst=0, instr_done=1.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, SUB, pc_src=01, instr_done=1.
  - pc_en = zero for BEQ, ~zero for BNE.
- JUMP: pc_src=10, pc_en=1, instr_done=1.
- All terminal states return to FETCH.
- wait_cnt:
  - 4 bits; increments each cycle spent in FETCH/MEMRD/MEMWR while wait_cnt<MEM_LAT.
  - Clears on any state change.
  - With MEM_LAT=0 each memory state lasts exactly 1 cycle.
- Instruction latency = base + k*MEM_LAT, where k = number of memory states.
  - Base cycles: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3.
  - k: lw 2, sw 2, all others 1.
- opcode/funct are sampled only in DECODE and EXEC. The datapath holds IR stable, so changes in any other state have no effect.

Test Plan:
- Reset hold: reset=1 for 3 cycles with opcode=100011 -> all outputs 0, state_dbg=FETCH. After release, ir_write=1 and pc_en=1 on cycle 1 (MEM_LAT=0).
- MEM_LAT=0, R-type funct=101010 -> 4 cycles; alu_control=111 in EXEC; reg_write=1, reg_dst=1 in cycle 4; instr_done on cycle 4 only.
- MEM_LAT=2, lw -> 9 cycles; ir_write on cycle 3 only; iord=1 on cycles 6-8; reg_write=1, mem_to_reg=1 on cycle 9.
- MEM_LAT=2, sw -> 8 cycles; mem_write=1 on cycles 6-8 exactly; reg_write=0 throughout.
- beq with zero=1 -> pc_en=1, pc_src=01 on cycle 3. bne with zero=1 -> pc_en=0. ENABLE_BNE=0 with opcode 000101 -> illegal_op pulse on cycle 2, then back to FETCH on cycle 3.
- Reset asserted in MEMWR (MEM_LAT=3) -> mem_write drops to 0 in the same cycle, state=FETCH on the next cycle, and no instr_done pulse.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//
// Control FSM for the multicycle MIPS datapath. Each instruction is walked
// through fetch, decode, execute, memory and writeback states. The FSM drives
// the datapath mux selects, the write enables and the ALU control word.
// MEM_LAT adds wait cycles to every memory access (FETCH, MEMRD, MEMWR), so
// the same block serves the zero-wait-state build and the slow-memory build.
//
// Parameters:
//   MEM_LAT     extra wait cycles per memory access (0..15)
//   ENABLE_BNE  1 = decode BNE (000101), 0 = treat it as illegal
//   ENABLE_J    1 = decode J (000010), 0 = treat it as illegal
//   ALU_CTRL_W  width of alu_control_o
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous, active-high; forces every output to 0
//   opcode_i       instr[31:26] from the instruction register
//   funct_i        instr[5:0] from the instruction register
//   zero_i         ALU zero flag
//   iord_o         memory address select (0 = PC, 1 = ALUOut)
//   ir_write_o     instruction register load
//   mem_write_o    data memory write
//   mem_to_reg_o   writeback select (1 = memory data)
//   reg_dst_o      destination select (1 = rd)
//   reg_write_o    register file write
//   alu_src_a_o    ALU A select (0 = PC, 1 = rs)
//   alu_src_b_o    ALU B select (00 rt, 01 const 4, 10 signimm, 11 signimm<<2)
//   pc_src_o       next-PC select (00 ALU result, 01 ALUOut, 10 jump target)
//   pc_en_o        PC load enable
//   alu_control_o  ALU operation
//   instr_done_o   pulse on the final cycle of each instruction
//   illegal_op_o   pulse when an unsupported opcode is decoded
//   state_dbg_o    current state encoding
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter int MEM_LAT    = 0,
    parameter int ENABLE_BNE = 1,
    parameter int ENABLE_J   = 1,
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [5:0]            opcode_i,
    input  logic [5:0]            funct_i,
    input  logic                  zero_i,
    output logic                  iord_o,
    output logic                  ir_write_o,
    output logic                  mem_write_o,
    output logic                  mem_to_reg_o,
    output logic                  reg_dst_o,
    output logic                  reg_write_o,
    output logic                  alu_src_a_o,
    output logic [1:0]            alu_src_b_o,
    output logic [1:0]            pc_src_o,
    output logic                  pc_en_o,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic                  instr_done_o,
    output logic                  illegal_op_o,
    output logic [3:0]            state_dbg_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       is_sw_q, is_sw_d;
    logic       is_bne_q, is_bne_d;
    logic       mem_state;
    logic       mem_done;

    // The opcode is only trusted in DECODE, so the two facts needed later
    // (store vs load, BNE vs BEQ) are captured there and carried forward.
    // wait_cnt restarts on every state change and saturates at MEM_LAT.
    always_comb begin
        state_d   = state_q;
        is_sw_d   = is_sw_q;
        is_bne_d  = is_bne_q;
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        mem_done  = (wait_q == LAT);

        case (state_q)
            S_FETCH:  if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d  = (opcode_i == OP_SW);
                is_bne_d = (opcode_i == OP_BNE);
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_BNE:       state_d = (ENABLE_BNE != 0) ? S_BRANCH : S_FETCH;
                    OP_J:         state_d = (ENABLE_J != 0) ? S_JUMP : S_FETCH;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_done) state_d = S_MEMWB;
            S_MEMWR:  if (mem_done) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase

        if (state_d != state_q) begin
            wait_d = 4'd0;
        end else if (mem_state && (wait_q < LAT)) begin
            wait_d = wait_q + 4'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_FETCH;
            wait_q   <= 4'd0;
            is_sw_q  <= 1'b0;
            is_bne_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            is_sw_q  <= is_sw_d;
            is_bne_q <= is_bne_d;
        end
    end

    // Moore decode of the current state. Reset gates every output so that a
    // write in progress is dropped in the same cycle reset rises. An illegal
    // opcode is recognised as DECODE falling straight back to FETCH.
    always_comb begin
        iord_o        = 1'b0;
        ir_write_o    = 1'b0;
        mem_write_o   = 1'b0;
        mem_to_reg_o  = 1'b0;
        reg_dst_o     = 1'b0;
        reg_write_o   = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        pc_src_o      = 2'b00;
        pc_en_o       = 1'b0;
        alu_control_o = '0;
        instr_done_o  = 1'b0;
        illegal_op_o  = 1'b0;
        state_dbg_o   = 4'd0;

        if (!reset_i) begin
            state_dbg_o = state_q;
            case (state_q)
                S_FETCH: begin
                    alu_src_b_o   = 2'b01;
                    alu_control_o = ALU_ADD;
                    ir_write_o    = mem_done;
                    pc_en_o       = mem_done;
                end
                S_DECODE: begin
                    alu_src_b_o   = 2'b11;
                    alu_control_o = ALU_ADD;
                    illegal_op_o  = (state_d == S_FETCH);
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a_o   = 1'b1;
                    alu_src_b_o   = 2'b10;
                    alu_control_o = ALU_ADD;
                end
                S_MEMRD: iord_o = 1'b1;
                S_MEMWB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_MEMWR: begin
                    iord_o       = 1'b1;
                    mem_write_o  = 1'b1;
                    instr_done_o = mem_done;
                end
                S_EXEC: begin
                    alu_src_a_o = 1'b1;
                    case (funct_i)
                        6'b100010: alu_control_o = ALU_SUB;
                        6'b100100: alu_control_o = ALU_AND;
                        6'b100101: alu_control_o = ALU_OR;
                        6'b101010: alu_control_o = ALU_SLT;
                        default:   alu_control_o = ALU_ADD;
                    endcase
                end
                S_ALUWB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_ADDIWB: begin
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o   = 1'b1;
                    alu_control_o = ALU_SUB;
                    pc_src_o      = 2'b01;
                    pc_en_o       = is_bne_q ? ~zero_i : zero_i;
                    instr_done_o  = 1'b1;
                end
                S_JUMP: begin
                    pc_src_o     = 2'b10;
                    pc_en_o      = 1'b1;
                    instr_done_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control
//
// Bench for the multicycle control FSM. Four instances cover the build
// variants: 0 = MEM_LAT 0, 1 = MEM_LAT 2, 2 = MEM_LAT 3, 3 = MEM_LAT 0 with
// BNE and J disabled. Directed scenarios check the timing landmarks; a random
// back-to-back stream is checked cycle by cycle against a phase-list model
// that expands each instruction into its expected output cycles.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

    localparam int NDUT = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic       iord;
        logic       irWrite;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic       pcEn;
        logic [2:0] aluCtrl;
        logic       instrDone;
        logic       illegalOp;
    } outs_t;

    typedef struct packed {
        outs_t      exp;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       fetch;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst [NDUT];
    logic [5:0] opc [NDUT];
    logic [5:0] fun [NDUT];
    logic       zer [NDUT];
    outs_t      obs [NDUT];
    logic [3:0] stDbg [NDUT];

    int   passCount  = 0;
    int   checkCount = 0;
    cyc_t cycQ [$];

    always #5 clk = ~clk;

    // One instance per build variant, all sharing the clock.
    generate
        for (genvar g = 0; g < NDUT; g++) begin : gDut
            logic       iord, irWrite, memWrite, memToReg, regDst, regWrite, aluSrcA;
            logic [1:0] aluSrcB, pcSrc;
            logic       pcEn, instrDone, illegalOp;
            logic [2:0] aluCtrl;
            logic [3:0] st;

            mips_multicycle_control #(
                .MEM_LAT   (g == 1 ? 2 : (g == 2 ? 3 : 0)),
                .ENABLE_BNE(g == 3 ? 0 : 1),
                .ENABLE_J  (g == 3 ? 0 : 1),
                .ALU_CTRL_W(3)
            ) dut (
                .clk_i        (clk),
                .reset_i      (rst[g]),
                .opcode_i     (opc[g]),
                .funct_i      (fun[g]),
                .zero_i       (zer[g]),
                .iord_o       (iord),
                .ir_write_o   (irWrite),
                .mem_write_o  (memWrite),
                .mem_to_reg_o (memToReg),
                .reg_dst_o    (regDst),
                .reg_write_o  (regWrite),
                .alu_src_a_o  (aluSrcA),
                .alu_src_b_o  (aluSrcB),
                .pc_src_o     (pcSrc),
                .pc_en_o      (pcEn),
                .alu_control_o(aluCtrl),
                .instr_done_o (instrDone),
                .illegal_op_o (illegalOp),
                .state_dbg_o  (st)
            );

            assign obs[g]   = {iord, irWrite, memWrite, memToReg, regDst, regWrite, aluSrcA,
                               aluSrcB, pcSrc, pcEn, aluCtrl, instrDone, illegalOp};
            assign stDbg[g] = st;
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic int latOf(input int d);
        return (d == 1) ? 2 : ((d == 2) ? 3 : 0);
    endfunction

    function automatic logic [5:0] junk6();
        return 6'($urandom);
    endfunction

    function automatic logic [2:0] aluOf(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return 3'b110;
            FN_AND:  return 3'b000;
            FN_OR:   return 3'b001;
            FN_SLT:  return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit legalOp(input int d, input logic [5:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ: return 1'b1;
            OP_BNE, OP_J: return (d != 3);
            default: return 1'b0;
        endcase
    endfunction

    function automatic cyc_t mkCyc(input outs_t e, input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input logic f);
        cyc_t c;
        c.exp = e; c.op = op; c.fn = fn; c.z = z; c.fetch = f;
        return c;
    endfunction

    // Expands one instruction into its expected cycles. The real opcode is
    // only presented in DECODE and the real funct only in EXEC; every other
    // cycle carries random garbage, which the controller must ignore.
    task automatic buildInstr(input int d, input logic [5:0] op, input logic [5:0] fn, input logic z);
        int    lat;
        outs_t e;
        lat = latOf(d);
        for (int i = 0; i <= lat; i++) begin
            e = '0; e.aluSrcB = 2'b01; e.aluCtrl = 3'b010;
            if (i == lat) begin e.irWrite = 1'b1; e.pcEn = 1'b1; end
            cycQ.push_back(mkCyc(e, junk6(), junk6(), 1'($urandom), 1'b1));
        end
        e = '0; e.aluSrcB = 2'b11; e.aluCtrl = 3'b010; e.illegalOp = !legalOp(d, op);
        cycQ.push_back(mkCyc(e, op, junk6(), 1'($urandom), 1'b0));
        if (!legalOp(d, op)) return;
        case (op)
            OP_LW, OP_SW: begin
                e = '0; e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluCtrl = 3'b010;
                cycQ.push_back(mkCyc(e, junk6(), junk6(), 1'($urandom), 1'b0));
                for (int i = 0; i <= lat; i++) begin
                    e = '0; e.iord = 1'b1;
                    if (op == OP_SW) begin e.memWrite = 1'b1; e.instrDone = (i == lat); end
                    cycQ.push_back(mkCyc(e, junk6(), junk6(), 1'($urandom), 1'b0));
                end
                if (op == OP_LW) begin
                    e = '0; e.regWrite = 1'b1; e.memToReg = 1'b1; e.instrDone = 1'b1;
                    cycQ.push_back(mkCyc(e, junk6(), junk6(), 1'($urandom), 1'b0));
                end
            end
            OP_RTYPE: begin
                e = '0; e.aluSrcA = 1'b1; e.aluCtrl = aluOf(fn);
                cycQ.push_back(mkCyc(e, junk6(), fn, 1'($urandom), 1'b0));
                e = '0; e.regWrite = 1'b1; e.regDst = 1'b1; e.instrDone = 1'b1;
                cycQ.push_back(mkCyc(e, junk6(), junk6(), 1'($urandom), 1'b0));
            end
            OP_ADDI: begin
                e = '0; e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluCtrl = 3'b010;
                cycQ.push_back(mkCyc(e, junk6(), junk6(), 1'($urandom), 1'b0));
                e = '0; e.regWrite = 1'b1; e.instrDone = 1'b1;
                cycQ.push_back(mkCyc(e, junk6(), junk6(), 1'($urandom), 1'b0));
            end
            OP_BEQ, OP_BNE: begin
                e = '0; e.aluSrcA = 1'b1; e.aluCtrl = 3'b110; e.pcSrc = 2'b01; e.instrDone = 1'b1;
                e.pcEn = (op == OP_BEQ) ? z : !z;
                cycQ.push_back(mkCyc(e, junk6(), junk6(), z, 1'b0));
            end
            default: begin
                e = '0; e.pcSrc = 2'b10; e.pcEn = 1'b1; e.instrDone = 1'b1;
                cycQ.push_back(mkCyc(e, junk6(), junk6(), 1'($urandom), 1'b0));
            end
        endcase
    endtask

    // ---------------- stimulus ----------------
    // Advances one clock: inputs change just after the rising edge and the
    // caller samples at the falling edge that follows.
    task automatic applyStimulus(input int d, input logic r, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z);
        @(posedge clk);
        #1;
        rst[d] = r; opc[d] = op; fun[d] = fn; zer[d] = z;
        @(negedge clk);
    endtask

    task automatic resetDut(input int d);
        applyStimulus(d, 1'b1, junk6(), junk6(), 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 1'b1, OP_LW, junk6(), 1'($urandom));
            checkCount++;
            if (obs[0] !== '0) $display("[TB] FAIL reset_outputs: got %h, expected 0", obs[0]);
            else passCount++;
            checkCount++;
            if (stDbg[0] !== 4'd0) $display("[TB] FAIL reset_state: got %0d, expected 0", stDbg[0]);
            else passCount++;
        end
        applyStimulus(0, 1'b0, OP_LW, junk6(), 1'b0);
        checkCount++;
        if ({obs[0].irWrite, obs[0].pcEn} !== 2'b11)
            $display("[TB] FAIL first_fetch: got %b, expected 11", {obs[0].irWrite, obs[0].pcEn});
        else passCount++;
    endtask

    task automatic test_rtype_slt();
        resetDut(0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 1'b0, OP_RTYPE, FN_SLT, 1'($urandom));
            if (k == 3) begin
                checkCount++;
                if (obs[0].aluCtrl !== 3'b111) $display("[TB] FAIL slt_alu: got %b, expected 111", obs[0].aluCtrl);
                else passCount++;
            end
            if (k == 4) begin
                checkCount++;
                if ({obs[0].regWrite, obs[0].regDst} !== 2'b11)
                    $display("[TB] FAIL rtype_wb: got %b, expected 11", {obs[0].regWrite, obs[0].regDst});
                else passCount++;
            end
            if (k <= 4) begin
                checkCount++;
                if (obs[0].instrDone !== (k == 4))
                    $display("[TB] FAIL rtype_done cycle %0d: got %b, expected %b", k, obs[0].instrDone, k == 4);
                else passCount++;
            end else begin
                checkCount++;
                if (stDbg[0] !== 4'd0) $display("[TB] FAIL rtype_refetch: got %0d, expected 0", stDbg[0]);
                else passCount++;
            end
        end
    endtask

    task automatic test_lw_slow();
        resetDut(1);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1, 1'b0, OP_LW, junk6(), 1'($urandom));
            checkCount++;
            if ({obs[1].irWrite, obs[1].iord, obs[1].instrDone} !== {k == 3, k >= 6 && k <= 8, k == 9})
                $display("[TB] FAIL lw_slow cycle %0d: got ir/iord/done %b, expected %b", k,
                         {obs[1].irWrite, obs[1].iord, obs[1].instrDone}, {k == 3, k >= 6 && k <= 8, k == 9});
            else passCount++;
        end
        checkCount++;
        if ({obs[1].regWrite, obs[1].memToReg} !== 2'b11)
            $display("[TB] FAIL lw_wb: got %b, expected 11", {obs[1].regWrite, obs[1].memToReg});
        else passCount++;
    endtask

    task automatic test_sw_slow();
        resetDut(1);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1, 1'b0, OP_SW, junk6(), 1'($urandom));
            if (k <= 8) begin
                checkCount++;
                if ({obs[1].memWrite, obs[1].regWrite, obs[1].instrDone} !== {k >= 6, 1'b0, k == 8})
                    $display("[TB] FAIL sw_slow cycle %0d: got mw/rw/done %b, expected %b", k,
                             {obs[1].memWrite, obs[1].regWrite, obs[1].instrDone}, {k >= 6, 1'b0, k == 8});
                else passCount++;
            end else begin
                checkCount++;
                if (stDbg[1] !== 4'd0) $display("[TB] FAIL sw_refetch: got %0d, expected 0", stDbg[1]);
                else passCount++;
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] op;
        logic       z;
        for (int i = 0; i < 4; i++) begin
            op = (i < 2) ? OP_BEQ : OP_BNE;
            z  = i[0];
            resetDut(0);
            for (int k = 1; k <= 3; k++) applyStimulus(0, 1'b0, op, junk6(), z);
            checkCount++;
            if ({obs[0].pcEn, obs[0].pcSrc, obs[0].instrDone} !== {(op == OP_BEQ) ? z : !z, 2'b01, 1'b1})
                $display("[TB] FAIL branch op=%b z=%b: got en/src/done %b, expected %b", op, z,
                         {obs[0].pcEn, obs[0].pcSrc, obs[0].instrDone}, {(op == OP_BEQ) ? z : !z, 2'b01, 1'b1});
            else passCount++;
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        ops = '{OP_BNE, OP_J};
        for (int i = 0; i < 2; i++) begin
            resetDut(3);
            for (int k = 1; k <= 3; k++) begin
                applyStimulus(3, 1'b0, ops[i], junk6(), 1'b1);
                checkCount++;
                if (obs[3].illegalOp !== (k == 2))
                    $display("[TB] FAIL illegal_pulse op=%b cycle %0d: got %b, expected %b", ops[i], k,
                             obs[3].illegalOp, k == 2);
                else passCount++;
                if (k == 2) begin
                    checkCount++;
                    if ({obs[3].regWrite, obs[3].memWrite, obs[3].irWrite, obs[3].pcEn, obs[3].instrDone} !== 5'b0)
                        $display("[TB] FAIL illegal_quiet: got %b, expected 00000",
                                 {obs[3].regWrite, obs[3].memWrite, obs[3].irWrite, obs[3].pcEn, obs[3].instrDone});
                    else passCount++;
                end
                if (k == 3) begin
                    checkCount++;
                    if (stDbg[3] !== 4'd0 || obs[3].irWrite !== 1'b1)
                        $display("[TB] FAIL illegal_refetch: got state %0d ir %b, expected 0 1", stDbg[3], obs[3].irWrite);
                    else passCount++;
                end
            end
        end
    endtask

    task automatic test_reset_memwr();
        resetDut(2);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(2, k == 8, OP_SW, junk6(), 1'($urandom));
            if (k == 7) begin
                checkCount++;
                if (obs[2].memWrite !== 1'b1) $display("[TB] FAIL memwr_before: got %b, expected 1", obs[2].memWrite);
                else passCount++;
            end
            if (k >= 8) begin
                checkCount++;
                if ({obs[2].memWrite, obs[2].instrDone} !== 2'b00)
                    $display("[TB] FAIL memwr_abort cycle %0d: got %b, expected 00", k, {obs[2].memWrite, obs[2].instrDone});
                else passCount++;
            end
            if (k == 9) begin
                checkCount++;
                if (stDbg[2] !== 4'd0) $display("[TB] FAIL memwr_refetch: got %0d, expected 0", stDbg[2]);
                else passCount++;
            end
            if (k >= 9) begin
                checkCount++;
                if (obs[2].irWrite !== (k == 12))
                    $display("[TB] FAIL memwr_fetch_wait cycle %0d: got %b, expected %b", k, obs[2].irWrite, k == 12);
                else passCount++;
            end
        end
    endtask

    task automatic test_latency();
        logic [5:0] ops   [7];
        int         base  [7];
        int         kMem  [7];
        int         cycles;
        int         expect_;
        bit         done;
        ops  = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_BNE, OP_J};
        base = '{5, 4, 4, 4, 3, 3, 3};
        kMem = '{2, 2, 1, 1, 1, 1, 1};
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 7; i++) begin
                if (!legalOp(d, ops[i])) continue;
                resetDut(d);
                cycles = 0;
                done   = 1'b0;
                while (!done && cycles < 64) begin
                    applyStimulus(d, 1'b0, ops[i], FN_ADD, 1'($urandom));
                    cycles++;
                    done = (obs[d].instrDone === 1'b1);
                end
                expect_ = base[i] + kMem[i] * latOf(d);
                checkCount++;
                if (cycles !== expect_)
                    $display("[TB] FAIL latency dut%0d op=%b: got %0d cycles, expected %0d", d, ops[i], cycles, expect_);
                else passCount++;
            end
        end
    endtask

    task automatic test_random_back_to_back(input int d, input int n);
        logic [5:0] opList [9];
        logic [5:0] fnList [6];
        cyc_t       c;
        int         cyc;
        opList = '{OP_LW, OP_SW, OP_RTYPE, OP_RTYPE, OP_ADDI, OP_BEQ, OP_BNE, OP_J, 6'b0};
        fnList = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'b0};
        resetDut(d);
        cycQ.delete();
        for (int i = 0; i < n; i++) begin
            opList[8] = junk6();
            fnList[5] = junk6();
            buildInstr(d, opList[$urandom_range(0, 8)], fnList[$urandom_range(0, 5)], 1'($urandom));
        end
        cyc = 0;
        while (cycQ.size() > 0) begin
            c = cycQ.pop_front();
            cyc++;
            applyStimulus(d, 1'b0, c.op, c.fn, c.z);
            checkCount++;
            if (obs[d] !== c.exp)
                $display("[TB] FAIL random dut%0d cycle %0d: got %h, expected %h", d, cyc, obs[d], c.exp);
            else passCount++;
            checkCount++;
            if ((stDbg[d] === 4'd0) !== c.fetch)
                $display("[TB] FAIL random_fetch dut%0d cycle %0d: got state %0d, expected fetch=%b", d, cyc, stDbg[d], c.fetch);
            else passCount++;
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; opc[d] = 6'd0; fun[d] = 6'd0; zer[d] = 1'b0;
        end
        $display("[TB] starting");
        test_reset();
        test_rtype_slt();
        test_lw_slow();
        test_sw_slow();
        test_branch();
        test_illegal();
        test_reset_memwr();
        test_latency();
        for (int d = 0; d < NDUT; d++) test_random_back_to_back(d, 30);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
